gomoku_ctrl: RTL

GOMOKU_CTRL -- requirements
Module: gomoku_ctrl

---
 rtl/gomoku_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/gomoku_ctrl.sv
// gomoku_ctrl: turn/match controller for an N-player gomoku game.
// Sequences board clear, coordinate entry, judging, piece write and
// end-of-match handling. It also keeps a per-turn countdown and saturating
// per-player win counters.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   sw_power, btn_reset, btn_ok  power switch, match reset, confirm button
//   tick                         countdown strobe (counted in WAIT only)
//   key_valid/key_index/key_ready  coordinate entry handshake
//   memrst_en/memrst_done        board-clear request / completion
//   judge_en/judge_done/judge_result  judger request / result
//   pos                          selected cell {y,x}
//   ram_we/ram_wr_addr/ram_wr_data  board write port (data = player+1)
//   active_player, countdown     current turn owner, ticks remaining
//   win_count                    packed per-player win counters
//   buzzer_en                    high while the match has ended
//   state                        current FSM state code
module gomoku_ctrl #(
  parameter int EDGE_BITS   = 3,
  parameter int NUM_PLAYERS = 2,
  parameter int TURN_TICKS  = 10,
  parameter int WIN_BITS    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sw_power,
  input  logic                            btn_reset,
  input  logic                            btn_ok,
  input  logic                            tick,
  input  logic                            key_valid,
  input  logic [EDGE_BITS:0]              key_index,
  output logic                            key_ready,
  output logic                            memrst_en,
  input  logic                            memrst_done,
  output logic                            judge_en,
  input  logic                            judge_done,
  input  logic [1:0]                      judge_result,
  output logic [2*EDGE_BITS-1:0]          pos,
  output logic                            ram_we,
  output logic [2*EDGE_BITS-1:0]          ram_wr_addr,
  output logic [2:0]                      ram_wr_data,
  output logic [1:0]                      active_player,
  output logic [7:0]                      countdown,
  output logic [NUM_PLAYERS*WIN_BITS-1:0] win_count,
  output logic                            buzzer_en,
  output logic [2:0]                      state
);
  localparam int PW = 2*EDGE_BITS;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] BOARD_CELLS = {1'b1, {PW{1'b0}}};
  localparam logic [7:0]    TURN_LOAD   = 8'(TURN_TICKS);

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_JUDGE   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_END     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 ok_q, ok_rise;
  logic [1:0]           player_q, start_q;
  logic [CW-1:0]        pieces_q, pieces_inc;
  logic [EDGE_BITS-1:0] x_q, y_q;
  logic                 pressed_x_q, pressed_y_q;
  logic [7:0]           count_q;
  logic                 win_pending_q;
  logic [WIN_BITS-1:0]  wins_q [NUM_PLAYERS];
  logic                 key_take, turn_ready, turn_expire;

  function automatic logic [1:0] next_player(input logic [1:0] p);
    return (p == 2'(NUM_PLAYERS-1)) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [WIN_BITS-1:0] sat_inc(input logic [WIN_BITS-1:0] v);
    return (&v) ? v : v + WIN_BITS'(1);
  endfunction

  assign ok_rise     = btn_ok & ~ok_q;
  assign turn_ready  = pressed_x_q & pressed_y_q;
  assign turn_expire = tick && (count_q <= 8'd1);
  assign pieces_inc  = pieces_q + CW'(1);
  assign key_take    = key_valid & key_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_STOPPED;
    else        state_q <= state_d;
  end

  // Next state and strobes. Strobes are gated by rst_n so nothing fires
  // while reset is held, including a write that was in flight.
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    memrst_en = 1'b0;
    judge_en  = 1'b0;
    ram_we    = 1'b0;
    buzzer_en = 1'b0;
    if (!sw_power) begin
      state_d = ST_STOPPED;
    end else if (btn_reset) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_STOPPED: state_d = ST_CLEAR;
        ST_CLEAR:   if (memrst_done) state_d = ST_WAIT;
        // A confirm takes precedence over a tick arriving in the same cycle.
        ST_WAIT:    if (ok_rise && turn_ready) state_d = ST_JUDGE;
        ST_JUDGE:   if (judge_done)
                      state_d = (judge_result == 2'b01 || judge_result == 2'b10)
                                ? ST_WRITE : ST_WAIT;
        ST_WRITE:   state_d = (win_pending_q || pieces_inc == BOARD_CELLS)
                              ? ST_END : ST_WAIT;
        ST_END:     if (ok_rise) state_d = ST_CLEAR;
        default:    state_d = ST_STOPPED;
      endcase
    end
    if (rst_n) begin
      case (state_q)
        ST_CLEAR: memrst_en = 1'b1;
        ST_WAIT:  key_ready = 1'b1;
        ST_JUDGE: judge_en  = 1'b1;
        ST_WRITE: ram_we    = 1'b1;
        ST_END:   buzzer_en = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q          <= 1'b0;
      player_q      <= 2'd0;
      start_q       <= 2'd0;
      pieces_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pressed_x_q   <= 1'b0;
      pressed_y_q   <= 1'b0;
      count_q       <= 8'd0;
      win_pending_q <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) wins_q[p] <= '0;
    end else begin
      ok_q <= btn_ok;
      if (key_take) begin
        if (key_index[EDGE_BITS]) begin
          y_q         <= key_index[EDGE_BITS-1:0];
          pressed_y_q <= 1'b1;
        end else begin
          x_q         <= key_index[EDGE_BITS-1:0];
          pressed_x_q <= 1'b1;
        end
      end
      case (state_q)
        ST_CLEAR: if (state_d == ST_WAIT) begin
          player_q    <= start_q;
          pieces_q    <= '0;
          pressed_x_q <= 1'b0;
          pressed_y_q <= 1'b0;
          count_q     <= TURN_LOAD;
        end
        ST_WAIT: if (state_d == ST_WAIT && tick) begin
          // Expiry forfeits the turn; it also discards any half-entered move.
          if (turn_expire) begin
            player_q    <= next_player(player_q);
            count_q     <= TURN_LOAD;
            pressed_x_q <= 1'b0;
            pressed_y_q <= 1'b0;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        ST_JUDGE: begin
          if (state_d == ST_WAIT) begin
            pressed_x_q <= 1'b0;
            pressed_y_q <= 1'b0;
          end else if (state_d == ST_WRITE) begin
            win_pending_q <= judge_result[1];
          end
        end
        ST_WRITE: if (state_d == ST_END || state_d == ST_WAIT) begin
          pieces_q <= pieces_inc;
          if (state_d == ST_WAIT) begin
            player_q    <= next_player(player_q);
            count_q     <= TURN_LOAD;
            pressed_x_q <= 1'b0;
            pressed_y_q <= 1'b0;
          end else if (win_pending_q) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
              if (player_q == 2'(p)) wins_q[p] <= sat_inc(wins_q[p]);
          end
        end
        ST_END: if (state_d == ST_CLEAR) start_q <= next_player(start_q);
        default: ;
      endcase
      // Placed last so a match reset overrides the END start-player advance.
      if (sw_power && btn_reset) begin
        start_q <= 2'd0;
        for (int p = 0; p < NUM_PLAYERS; p++) wins_q[p] <= '0;
      end
    end
  end

  always_comb begin
    win_count = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      win_count[p*WIN_BITS +: WIN_BITS] = wins_q[p];
  end

  assign pos           = {y_q, x_q};
  assign ram_wr_addr   = pos;
  assign ram_wr_data   = 3'(player_q) + 3'd1;
  assign active_player = player_q;
  assign countdown     = count_q;
  assign state         = state_q;

endmodule
